// File: rtl/gerenciador_requisicoes_if.sv
// rtl/gerenciador_requisicoes_if.sv - request-manager bus: buttons/floor status in, pending/target out
interface gerenciador_requisicoes_if #(
    parameter int N_ANDARES = 5,
    parameter int W_ANDAR   = 3
);
    logic [N_ANDARES-1:0] req_btn;
    logic [W_ANDAR-1:0]   andar_atual;
    logic                 parado;
    logic [N_ANDARES-1:0] pendentes;
    logic [W_ANDAR-1:0]   andar_alvo;
    logic                 alvo_valido;
    logic [1:0]           direcao;
    logic                 atendido;

    modport master (
        output req_btn, andar_atual, parado,
        input  pendentes, andar_alvo, alvo_valido, direcao, atendido
    );

    modport slave (
        input  req_btn, andar_atual, parado,
        output pendentes, andar_alvo, alvo_valido, direcao, atendido
    );
endinterface

// File: rtl/gerenciador_requisicoes.sv
// rtl/gerenciador_requisicoes.sv - debounced floor-request latch with SCAN target selection
module gerenciador_requisicoes #(
    parameter int N_ANDARES       = 5,
    parameter int W_ANDAR         = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    gerenciador_requisicoes_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W_ANDAR:0] N_LIM = (W_ANDAR + 1)'(N_ANDARES);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        SUBINDO  = 2'b01,
        DESCENDO = 2'b10
    } dir_e;

    logic [N_ANDARES-1:0] sync1_q, sync2_q;
    logic [N_ANDARES-1:0] deb_q, deb_d, deb_prev_q;
    logic [CW-1:0]        cnt_q [N_ANDARES];
    logic [CW-1:0]        cnt_d [N_ANDARES];
    logic [N_ANDARES-1:0] pend_q, pend_d;
    logic [N_ANDARES-1:0] set_vec, clr_mask;
    logic                 atendido_q, atendido_d;
    logic                 valido_q, valido_d;
    logic [W_ANDAR-1:0]   alvo_q, alvo_d;
    dir_e                 state_q, state_d;
    logic                 in_range;
    logic                 any_above, any_below;
    logic [W_ANDAR-1:0]   low_above, high_below;

    assign in_range = ({1'b0, bus.andar_atual} < N_LIM);

    // Counter runs only while the synchronised level disagrees with the accepted one.
    always_comb begin
        for (int i = 0; i < N_ANDARES; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign set_vec = deb_q & ~deb_prev_q;

    // A fresh press at the stopped floor is cleared in the same cycle it would be set.
    always_comb begin
        for (int i = 0; i < N_ANDARES; i++) begin
            clr_mask[i] = bus.parado && in_range
                          && (bus.andar_atual == W_ANDAR'(i))
                          && (pend_q[i] || set_vec[i]);
        end
        pend_d     = (pend_q | set_vec) & ~clr_mask;
        atendido_d = |clr_mask;
        valido_d   = |pend_q;
    end

    always_comb begin
        any_above  = 1'b0;
        any_below  = 1'b0;
        low_above  = '0;
        high_below = '0;
        for (int i = N_ANDARES - 1; i >= 0; i--) begin
            if (pend_q[i] && (W_ANDAR'(i) > bus.andar_atual)) begin
                any_above = 1'b1;
                low_above = W_ANDAR'(i);
            end
        end
        for (int i = 0; i < N_ANDARES; i++) begin
            if (pend_q[i] && (W_ANDAR'(i) < bus.andar_atual)) begin
                any_below  = 1'b1;
                high_below = W_ANDAR'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        alvo_d  = alvo_q;
        if (pend_q == '0) begin
            state_d = OCIOSO;
        end else if (in_range) begin
            case (state_q)
                DESCENDO: begin
                    if (any_below) begin
                        alvo_d = high_below;
                    end else if (any_above) begin
                        state_d = SUBINDO;
                        alvo_d  = low_above;
                    end else begin
                        state_d = OCIOSO;
                        alvo_d  = bus.andar_atual;
                    end
                end
                default: begin
                    // OCIOSO and SUBINDO both prefer going up first.
                    if (any_above) begin
                        state_d = SUBINDO;
                        alvo_d  = low_above;
                    end else if (any_below) begin
                        state_d = DESCENDO;
                        alvo_d  = high_below;
                    end else begin
                        state_d = OCIOSO;
                        alvo_d  = bus.andar_atual;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < N_ANDARES; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q     <= '0;
            atendido_q <= 1'b0;
            valido_q   <= 1'b0;
            alvo_q     <= '0;
            state_q    <= OCIOSO;
        end else begin
            sync1_q    <= bus.req_btn;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < N_ANDARES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q     <= pend_d;
            atendido_q <= atendido_d;
            valido_q   <= valido_d;
            alvo_q     <= alvo_d;
            state_q    <= state_d;
        end
    end

    assign bus.pendentes   = pend_q;
    assign bus.andar_alvo  = alvo_q;
    assign bus.alvo_valido = valido_q;
    assign bus.direcao     = state_q;
    assign bus.atendido    = atendido_q;
endmodule

// File: tb/tb_gerenciador_requisicoes.sv
// tb/tb_gerenciador_requisicoes.sv - directed table and sequence checks for gerenciador_requisicoes
module tb_gerenciador_requisicoes;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    gerenciador_requisicoes_if #(.N_ANDARES(5), .W_ANDAR(3)) bus ();

    gerenciador_requisicoes #(
        .N_ANDARES(5),
        .W_ANDAR(3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] btn;
        logic [2:0] atual;
        logic       parado;
        int         ciclos;
        logic [4:0] pend;
        logic [1:0] dir;
        logic [2:0] alvo;
        logic       valido;
        logic       at;
    } vec_t;

    vec_t tab [9];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nome, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] p, input logic [1:0] d,
                           input logic [2:0] a, input logic v, input logic at);
        chk({tag, ".pendentes"}, 32'(bus.pendentes), 32'(p));
        chk({tag, ".direcao"}, 32'(bus.direcao), 32'(d));
        chk({tag, ".andar_alvo"}, 32'(bus.andar_alvo), 32'(a));
        chk({tag, ".alvo_valido"}, 32'(bus.alvo_valido), 32'(v));
        chk({tag, ".atendido"}, 32'(bus.atendido), 32'(at));
    endtask

    initial begin
        int  n_at;
        logic seen_set, seen_dir, seen_at;

        tab[0] = '{5'b10011, 3'd2, 1'b0, 10, 5'b10011, 2'b01, 3'd4, 1'b1, 1'b0};
        tab[1] = '{5'b00000, 3'd2, 1'b0, 10, 5'b10011, 2'b01, 3'd4, 1'b1, 1'b0};
        tab[2] = '{5'b00000, 3'd4, 1'b1, 1,  5'b00011, 2'b10, 3'd1, 1'b1, 1'b1};
        tab[3] = '{5'b00000, 3'd4, 1'b1, 2,  5'b00011, 2'b10, 3'd1, 1'b1, 1'b0};
        tab[4] = '{5'b00000, 3'd1, 1'b1, 1,  5'b00001, 2'b10, 3'd0, 1'b1, 1'b1};
        tab[5] = '{5'b00000, 3'd0, 1'b1, 2,  5'b00000, 2'b00, 3'd0, 1'b0, 1'b0};
        tab[6] = '{5'b00100, 3'd0, 1'b0, 10, 5'b00100, 2'b01, 3'd2, 1'b1, 1'b0};
        tab[7] = '{5'b10100, 3'd0, 1'b0, 10, 5'b10100, 2'b01, 3'd2, 1'b1, 1'b0};
        tab[8] = '{5'b00000, 3'd0, 1'b0, 10, 5'b10100, 2'b01, 3'd2, 1'b1, 1'b0};

        bus.req_btn     = '0;
        bus.andar_atual = '0;
        bus.parado      = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk_all("reset", 5'b00000, 2'b00, 3'd0, 1'b0, 1'b0);

        bus.req_btn = 5'b01000;
        tick(3);
        bus.req_btn = '0;
        tick(12);
        chk("short_pulse.pendentes", 32'(bus.pendentes), 32'd0);

        bus.req_btn = 5'b01000;
        tick(7);
        chk("latency.before", 32'(bus.pendentes), 32'd0);
        tick(1);
        chk("latency.at7", 32'(bus.pendentes), 32'b01000);
        bus.req_btn = '0;
        tick(1);
        chk_all("first_target", 5'b01000, 2'b01, 3'd3, 1'b1, 1'b0);
        tick(10);

        bus.andar_atual = 3'd3;
        bus.parado      = 1'b1;
        tick(1);
        chk("serve3.atendido", 32'(bus.atendido), 32'd1);
        chk("serve3.pendentes", 32'(bus.pendentes), 32'd0);
        tick(1);
        chk_all("serve3.idle", 5'b00000, 2'b00, 3'd3, 1'b0, 1'b0);
        bus.parado = 1'b0;

        for (int i = 0; i < 9; i++) begin
            bus.req_btn     = tab[i].btn;
            bus.andar_atual = tab[i].atual;
            bus.parado      = tab[i].parado;
            tick(tab[i].ciclos);
            chk_all($sformatf("row%0d", i), tab[i].pend, tab[i].dir, tab[i].alvo,
                    tab[i].valido, tab[i].at);
        end

        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 5'b00000, 2'b00, 3'd0, 1'b0, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(2);

        bus.andar_atual = 3'd1;
        bus.parado      = 1'b1;
        bus.req_btn     = 5'b00010;
        n_at     = 0;
        seen_set = 1'b0;
        seen_dir = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick(1);
            if (bus.atendido) n_at++;
            if (bus.pendentes[1]) seen_set = 1'b1;
            if (bus.direcao != 2'b00) seen_dir = 1'b1;
        end
        chk("arrival.atendido_count", 32'(n_at), 32'd1);
        chk("arrival.bit_seen", 32'(seen_set), 32'd0);
        chk("arrival.dir_moved", 32'(seen_dir), 32'd0);
        bus.req_btn = '0;
        bus.parado  = 1'b0;
        tick(10);

        bus.andar_atual = 3'd3;
        bus.req_btn     = 5'b00001;
        tick(10);
        bus.req_btn = '0;
        tick(10);
        chk_all("pre_invalid", 5'b00001, 2'b10, 3'd0, 1'b1, 1'b0);
        bus.andar_atual = 3'd7;
        bus.parado      = 1'b1;
        seen_at = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (bus.atendido) seen_at = 1'b1;
        end
        chk("invalid.atendido_seen", 32'(seen_at), 32'd0);
        chk_all("invalid", 5'b00001, 2'b10, 3'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gerenciador_requisicoes.md
Name: gerenciador_requisicoes

Overview:
- Request-management stage directly upstream of the elevator controller.
- Conditions the raw floor-request buttons: synchronises and debounces them, then latches them into a pending-request register.
- Picks the next target floor with a SCAN (directional) policy and presents it to the controller as andar_alvo.
- Clears a request when the controller reports that the car is stopped at that floor.

Parameters:
N_ANDARES, 5, number of floors; request vector width.
W_ANDAR, 3, floor-index width; must satisfy 2**W_ANDAR >= N_ANDARES.
DEBOUNCE_CYCLES, 4, consecutive stable clk cycles needed to accept a button level change; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
req_btn  input  N_ANDARES  raw floor buttons, active-high, asynchronous to clk.
andar_atual  input  W_ANDAR  current floor reported by the elevator controller.
parado  input  1  1 = car stopped at andar_atual with doors serviceable.
pendentes  output  N_ANDARES  latched pending requests; bit i = floor i.
andar_alvo  output  W_ANDAR  selected target floor.
alvo_valido  output  1  1 = andar_alvo is meaningful (at least one request pending).
direcao  output  2  scan state: 00 OCIOSO, 01 SUBINDO, 10 DESCENDO; 11 never driven.
atendido  output  1  one-cycle pulse when a pending request is cleared.

Behaviour:
- Reset (reset=0, asynchronous):
  - pendentes=0, andar_alvo=0, alvo_valido=0, direcao=OCIOSO, atendido=0.
  - Synchronisers, debounced levels and debounce counters all cleared.
  - Reset release is synchronous to clk.
- Input conditioning, per bit:
  - 2-FF synchroniser feeds a debounce counter.
  - The counter increments while the synchronised value differs from the debounced level; it resets to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles after synchronisation never change the level.
- Latching:
  - A 0->1 edge of a debounced level sets the matching pendentes bit.
  - Total latency from the first sampled high on req_btn[i] to pendentes[i]=1 is DEBOUNCE_CYCLES+3 cycles.
  - Holding a button does not re-trigger; releasing it does not clear the request.
- Clearing:
  - If parado=1, andar_atual<N_ANDARES and pendentes[andar_atual]=1, that bit is cleared next cycle and atendido pulses high for exactly that cycle.
  - If a set and a clear hit the same bit in the same cycle, the clear wins and atendido pulses; a request at the stopped floor is served immediately.
- Out-of-range floor: if andar_atual>=N_ANDARES, no clear occurs and direcao/andar_alvo hold their values.
- Target selection: registered, and reflects pendentes/andar_atual one cycle after they change.
- FSM:
  - OCIOSO:
    - If there is a pending request above andar_atual, go to SUBINDO; otherwise, if there is one below, go to DESCENDO.
    - If only the current floor is pending: stay in OCIOSO with andar_alvo=andar_atual.
  - SUBINDO:
    - andar_alvo = lowest pending floor > andar_atual.
    - If no such floor exists: go to DESCENDO if any floor below is pending, else OCIOSO.
  - DESCENDO: mirror of SUBINDO; andar_alvo = highest pending floor < andar_atual.
  - alvo_valido=1 iff pendentes != 0. When pendentes=0: direcao returns to OCIOSO and andar_alvo holds its last value.
- Direction changes happen only through the transitions above; no reversal while a request remains ahead in the current direction.

Test Plan:
- Reset mid-operation: pendentes=5'b10100, direcao=SUBINDO, then reset=0 -> all outputs 0 immediately (asynchronously), before the next clk edge.
- Debounce, DEBOUNCE_CYCLES=4: req_btn[3] high for 3 cycles -> pendentes stays 0. Held for 8 cycles -> pendentes=5'b01000 exactly 7 cycles after the first sample, then next cycle alvo_valido=1, andar_alvo=3, direcao=SUBINDO (with andar_atual=0).
- Scan ordering: andar_atual=2, pendentes=5'b10011, direcao=SUBINDO -> andar_alvo=4. After parado=1 at floor 4 -> atendido pulses, pendentes=5'b00011, direcao=DESCENDO, andar_alvo=1.
- Serve on arrival: andar_atual=1, parado=1, press floor 1 -> bit never remains set, atendido pulses once, direcao stays OCIOSO.
- Drain: clear all requests one by one -> alvo_valido=0, direcao=OCIOSO, andar_alvo holds the last served floor.
- Invalid floor: andar_atual=7, parado=1, pendentes=5'b00001 -> no clear, atendido=0, direcao and andar_alvo unchanged.
